videobox_pio_edge_capture: RTL and testbench

Avalon-MM slave input port for the VideoBox SoPC. It is the input-direction counterpart of the LED output PIO and connects board push-buttons and switches to the Nios II. Each bit is synchronised, debounced and edge-detected, and the edges are latched in a write-1-to-clear capture register. A maskable level interrupt is raised while any unmasked capture bit is set.

---
 rtl/videobox_pio_edge_capture_if.sv | 12 +
 rtl/videobox_pio_edge_capture.sv | 119 +++++++++++
 tb/tb_videobox_pio_edge_capture.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/videobox_pio_edge_capture_if.sv
// Avalon-MM slave bus for the VideoBox input PIO.
// The master drives the access and the slave returns registered read data.
interface videobox_pio_edge_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/videobox_pio_edge_capture.sv
// Input PIO: per-bit synchroniser, debouncer and edge capture, exposed as
// DATA / IRQ_MASK / EDGE_CAPTURE registers, with a maskable level interrupt.
module videobox_pio_edge_capture_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    input  logic mask_we,
    input  logic cap_we,
    input  logic wbit,
    output logic db,
    output logic cap,
    output logic mask
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sr;
    logic [CW-1:0]          cnt;
    logic                   sync;
    logic                   upd;
    logic                   set;

    assign sync = sr[SYNC_STAGES-1];
    // db flips on the edge where a disagreeing level has held for the full count
    assign upd  = (sync != db) && (cnt == CNT_MAX);

    always_comb begin
        set = 1'b0;
        if (EDGE_TYPE == 0)      set = upd & sync;
        else if (EDGE_TYPE == 1) set = upd & ~sync;
        else                     set = upd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr   <= '0;
            cnt  <= '0;
            db   <= 1'b0;
            cap  <= 1'b0;
            mask <= 1'b0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], in_bit};
            if (sync == db) begin
                cnt <= '0;
            end else if (upd) begin
                db  <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // a new edge beats a simultaneous write-1-to-clear
            cap <= set | (cap & ~(cap_we & wbit));
            if (mask_we) mask <= wbit;
        end
    end
endmodule

module videobox_pio_edge_capture #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    videobox_pio_edge_capture_if.slave  bus,
    input  logic [WIDTH-1:0]            in_port,
    output logic                        irq
);
    logic [WIDTH-1:0] db, cap, mask;
    logic             wr_en, mask_we, cap_we;
    logic [31:0]      rd_mux, readdata;
    logic             unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign mask_we      = wr_en && (bus.address == 2'd1);
    assign cap_we       = wr_en && (bus.address == 2'd2);
    assign unused_wdata = ^bus.writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        videobox_pio_edge_capture_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .EDGE_TYPE       (EDGE_TYPE)
        ) u_bit (
            .clk     (clk),
            .reset   (reset),
            .in_bit  (in_port[i]),
            .mask_we (mask_we),
            .cap_we  (cap_we),
            .wbit    (bus.writedata[i]),
            .db      (db[i]),
            .cap     (cap[i]),
            .mask    (mask[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            2'd0:    rd_mux[WIDTH-1:0] = db;
            2'd1:    rd_mux[WIDTH-1:0] = mask;
            2'd2:    rd_mux[WIDTH-1:0] = cap;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               readdata <= '0;
        else if (bus.chipselect) readdata <= rd_mux;
    end

    assign bus.readdata = readdata;
    assign irq          = |(cap & mask);
endmodule

// File: tb/tb_videobox_pio_edge_capture.sv
// Bench for the input PIO: three instances (rising, falling, any edge) share
// clock, reset and inputs; expected read values are queued then popped on output.
module tb_videobox_pio_edge_capture;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_port = 4'h0;
    logic       irq0, irq1, irq2;

    videobox_pio_edge_capture_if bus0 ();
    videobox_pio_edge_capture_if bus1 ();
    videobox_pio_edge_capture_if bus2 ();

    videobox_pio_edge_capture #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_r (
        .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port), .irq(irq0));
    videobox_pio_edge_capture #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_f (
        .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port), .irq(irq1));
    videobox_pio_edge_capture #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset(reset), .bus(bus2), .in_port(in_port), .irq(irq2));

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got, exp;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
        bus0.chipselect = cs; bus0.write_n = wn; bus0.address = a; bus0.writedata = d;
        bus1.chipselect = cs; bus1.write_n = wn; bus1.address = a; bus1.writedata = d;
        bus2.chipselect = cs; bus2.write_n = wn; bus2.address = a; bus2.writedata = d;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        set_bus(1'b1, 1'b0, a, d);
        tick(1);
        set_bus(1'b0, 1'b1, a, 32'h0);
    endtask

    function automatic logic [31:0] rdata(input int idx);
        case (idx)
            0:       return bus0.readdata;
            1:       return bus1.readdata;
            default: return bus2.readdata;
        endcase
    endfunction

    task automatic bus_rd(input int idx, input logic [1:0] a, output logic [31:0] d);
        set_bus(1'b1, 1'b1, a, 32'h0);
        tick(1);
        d = rdata(idx);
        set_bus(1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic test_reset();
        set_bus(1'b0, 1'b1, 2'd0, 32'h0);
        tick(3);
        nvec++; if (bus0.readdata !== 32'h0) begin nerr++; $display("FAIL reset_readdata got=%h exp=0", bus0.readdata); end
        nvec++; if ({irq0, irq1, irq2} !== 3'b000) begin nerr++; $display("FAIL reset_irq got=%b exp=000", {irq0, irq1, irq2}); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_rising();
        bus_wr(2'd1, 32'h1);
        in_port = 4'h1;
        tick(5);
        nvec++; if (irq0 !== 1'b0) begin nerr++; $display("FAIL rise_irq_early got=%b exp=0", irq0); end
        tick(1);
        nvec++; if (irq0 !== 1'b1) begin nerr++; $display("FAIL rise_irq_e6 got=%b exp=1", irq0); end
        exp_q.push_back(32'h1); bus_rd(0, 2'd0, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL rise_data got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h1); bus_rd(0, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL rise_cap got=%h exp=%h", got, exp); end
        bus_wr(2'd1, 32'h0);
        nvec++; if (irq0 !== 1'b0) begin nerr++; $display("FAIL rise_irq_masked got=%b exp=0", irq0); end
    endtask

    task automatic test_glitch();
        in_port = 4'h3; tick(3);
        in_port = 4'h1; tick(8);
        exp_q.push_back(32'h1); bus_rd(0, 2'd0, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL glitch_data got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h1); bus_rd(0, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL glitch_cap got=%h exp=%h", got, exp); end
        nvec++; if (irq0 !== 1'b0) begin nerr++; $display("FAIL glitch_irq got=%b exp=0", irq0); end
        in_port = 4'h3; tick(4);
        in_port = 4'h1; tick(2);
        exp_q.push_back(32'h3); bus_rd(0, 2'd0, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL hold4_data got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h3); bus_rd(0, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL hold4_cap got=%h exp=%h", got, exp); end
        tick(10);
    endtask

    task automatic test_w1c();
        bus_wr(2'd1, 32'h2);
        nvec++; if (irq0 !== 1'b1) begin nerr++; $display("FAIL w1c_irq_pre got=%b exp=1", irq0); end
        bus_wr(2'd2, 32'h1);
        exp_q.push_back(32'h2); bus_rd(0, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL w1c_cap got=%h exp=%h", got, exp); end
        nvec++; if (irq0 !== 1'b1) begin nerr++; $display("FAIL w1c_irq_kept got=%b exp=1", irq0); end
        bus_wr(2'd2, 32'h2);
        nvec++; if (irq0 !== 1'b0) begin nerr++; $display("FAIL w1c_irq_clr got=%b exp=0", irq0); end
        in_port = 4'h5; tick(5);
        bus_wr(2'd2, 32'h4);
        exp_q.push_back(32'h4); bus_rd(0, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL set_wins got=%h exp=%h", got, exp); end
        bus_wr(2'd2, 32'h4);
        exp_q.push_back(32'h0); bus_rd(0, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL w1c_bit2 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_edge_type();
        bus_wr(2'd2, 32'hF);
        in_port = 4'hD; tick(8);
        exp_q.push_back(32'h0); bus_rd(1, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL fall_on_rise got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h8); bus_rd(2, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL any_on_rise got=%h exp=%h", got, exp); end
        bus_wr(2'd2, 32'hF);
        in_port = 4'h5; tick(8);
        exp_q.push_back(32'h8); bus_rd(1, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL fall_on_fall got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h8); bus_rd(2, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL any_on_fall got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h0); bus_rd(0, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL rise_on_fall got=%h exp=%h", got, exp); end
    endtask

    task automatic test_regmap();
        bus_wr(2'd1, 32'hFFFF_FFFF);
        exp_q.push_back(32'hF); bus_rd(0, 2'd1, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL mask_rb got=%h exp=%h", got, exp); end
        nvec++; if (irq1 !== 1'b1) begin nerr++; $display("FAIL irq_fall_dut got=%b exp=1", irq1); end
        bus_wr(2'd3, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0); bus_rd(0, 2'd3, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL addr3 got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h5); bus_rd(0, 2'd0, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL data_rb got=%h exp=%h", got, exp); end
        set_bus(1'b0, 1'b1, 2'd1, 32'h0);
        tick(2);
        nvec++; if (bus0.readdata !== 32'h5) begin nerr++; $display("FAIL rd_hold got=%h exp=5", bus0.readdata); end
        set_bus(1'b1, 1'b1, 2'd1, 32'h0);
        tick(1);
        set_bus(1'b0, 1'b1, 2'd1, 32'h0);
        nvec++; if (bus0.readdata !== 32'hF) begin nerr++; $display("FAIL rd_update got=%h exp=f", bus0.readdata); end
    endtask

    task automatic test_reset_mid();
        bus_wr(2'd2, 32'hF);
        in_port = 4'h0; tick(8);
        in_port = 4'hF; tick(8);
        exp_q.push_back(32'hF); bus_rd(0, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL pre_rst_cap got=%h exp=%h", got, exp); end
        nvec++; if (irq0 !== 1'b1) begin nerr++; $display("FAIL pre_rst_irq got=%b exp=1", irq0); end
        in_port = 4'h0; tick(4);
        reset = 1'b1; #1;
        nvec++; if (bus0.readdata !== 32'h0) begin nerr++; $display("FAIL rst_readdata got=%h exp=0", bus0.readdata); end
        nvec++; if ({irq0, irq1, irq2} !== 3'b000) begin nerr++; $display("FAIL rst_irq got=%b exp=000", {irq0, irq1, irq2}); end
        tick(2);
        reset = 1'b0; tick(10);
        exp_q.push_back(32'h0); bus_rd(0, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL post_rst_cap got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h0); bus_rd(2, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL post_rst_cap_any got=%h exp=%h", got, exp); end
        reset = 1'b1; in_port = 4'h2; tick(2);
        reset = 1'b0; tick(8);
        exp_q.push_back(32'h2); bus_rd(0, 2'd2, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL held_high_cap got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h2); bus_rd(0, 2'd0, got); exp = exp_q.pop_front();
        nvec++; if (got !== exp) begin nerr++; $display("FAIL held_high_data got=%h exp=%h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_glitch();
        test_w1c();
        test_edge_type();
        test_regmap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
